// File: rtl/arb_mux_pkg.sv
// Shared constants and helpers for the arbitrated registered multiplexer.
package arb_mux_pkg;

  localparam int MODE_RR    = 0;
  localparam int MODE_FIXED = 1;

  // Width of a channel index; a single channel still needs one bit.
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/arb_mux_rr_arbiter.sv
// Combinational arbiter: round-robin from ptr_i, or fixed lowest-index priority.
module rr_arbiter
  import arb_mux_pkg::*;
#(
  parameter int N    = 4,
  parameter int MODE = MODE_RR,
  localparam int SELW = sel_w(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [SELW-1:0] ptr_i,
  output logic [N-1:0]    grant_o,
  output logic [SELW-1:0] idx_o
);

  logic [2*N-1:0] masked_s;
  int             pick_s;

  // Lower copy masked below ptr; the lowest surviving bit of the doubled vector,
  // taken modulo N, is the winner, so the upper copy provides the wrap-around.
  always_comb begin
    masked_s = {req_i, req_i};
    pick_s   = 0;
    for (int k = 0; k < N; k++) begin
      masked_s[k] = (MODE == MODE_RR && k < int'(ptr_i)) ? 1'b0 : req_i[k];
    end
    for (int k = 2*N-1; k >= 0; k--) begin
      pick_s = masked_s[k] ? (k % N) : pick_s;
    end
    grant_o = (|req_i) ? (N'(1) << pick_s) : '0;
    idx_o   = SELW'(pick_s);
  end

endmodule

// File: rtl/arb_mux.sv
// N-channel arbitrated multiplexer with a one-entry registered output stage.
module arb_mux
  import arb_mux_pkg::*;
#(
  parameter int W    = 8,
  parameter int N    = 4,
  parameter int MODE = MODE_RR,
  localparam int SELW = sel_w(N)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [N*W-1:0]  A_in,
  input  logic [N-1:0]    valid_in,
  output logic [N-1:0]    ready_out,
  output logic [W-1:0]    Out_out,
  output logic            valid_out,
  input  logic            ready_in,
  output logic [SELW-1:0] sel_out
);

  logic [SELW-1:0] ptr_q, ptr_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic [W-1:0]    out_q, out_d;
  logic            valid_q, valid_d;
  logic [N-1:0]    grant_s;
  logic [SELW-1:0] idx_s;
  logic [W-1:0]    word_s;
  logic            load_en_s;
  logic            xfer_s;

  rr_arbiter #(.N(N), .MODE(MODE)) u_arb (
    .req_i   (valid_in),
    .ptr_i   (ptr_q),
    .grant_o (grant_s),
    .idx_o   (idx_s)
  );

  // Handshake, data selection and next state of the output register and pointer.
  always_comb begin
    load_en_s = ~valid_q | ready_in;
    ready_out = grant_s & {N{load_en_s & reset_n}};
    xfer_s    = |(ready_out & valid_in);
    word_s    = '0;
    for (int k = 0; k < N; k++) begin
      word_s = (idx_s == SELW'(k)) ? A_in[k*W +: W] : word_s;
    end
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    out_d   = out_q;
    valid_d = valid_q;
    if (xfer_s) begin
      out_d   = word_s;
      sel_d   = idx_s;
      valid_d = 1'b1;
      if (MODE == MODE_RR) begin
        ptr_d = (idx_s == SELW'(N-1)) ? '0 : idx_s + 1'b1;
      end else begin
        ptr_d = ptr_q;
      end
    end else if (valid_q && ready_in) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // State register; an asynchronous reset discards any in-flight word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q   <= '0;
      sel_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  assign Out_out   = out_q;
  assign valid_out = valid_q;
  assign sel_out   = sel_q;

endmodule

// File: tb/tb_arb_mux.sv
// Bench for arb_mux: a round-robin and a fixed-priority instance against a queue-free reference model.
module tb_arb_mux;

  localparam int W = 8;
  localparam int N = 4;

  logic         clk;
  logic         reset_n;
  logic [31:0]  a_in;
  logic [3:0]   valid_in;
  logic         ready_in;
  logic [3:0]   rr_ready, fp_ready;
  logic [7:0]   rr_out, fp_out;
  logic         rr_valid, fp_valid;
  logic [1:0]   rr_sel, fp_sel;

  int checks = 0;
  int passes = 0;

  bit         m_valid [2];
  logic [7:0] m_data  [2];
  int         m_sel   [2];
  int         m_ptr   [2];

  arb_mux #(.W(W), .N(N), .MODE(0)) dut_rr (
    .clk(clk), .reset_n(reset_n), .A_in(a_in), .valid_in(valid_in),
    .ready_out(rr_ready), .Out_out(rr_out), .valid_out(rr_valid),
    .ready_in(ready_in), .sel_out(rr_sel)
  );

  arb_mux #(.W(W), .N(N), .MODE(1)) dut_fp (
    .clk(clk), .reset_n(reset_n), .A_in(a_in), .valid_in(valid_in),
    .ready_out(fp_ready), .Out_out(fp_out), .valid_out(fp_valid),
    .ready_in(ready_in), .sel_out(fp_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Winner for model d (0 = round-robin, 1 = fixed); -1 when nobody requests.
  function automatic int pick(int d, logic [3:0] v);
    for (int off = 0; off < N; off++) begin
      int ch;
      ch = (d == 1) ? off : (m_ptr[d] + off) % N;
      if (v[ch]) return ch;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_ready(int d);
    int c;
    c = pick(d, valid_in);
    if (!reset_n || c < 0 || (m_valid[d] && !ready_in)) return 4'b0000;
    return 4'b0001 << c;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_valid[d] = 1'b0; m_data[d] = 8'h00; m_sel[d] = 0; m_ptr[d] = 0;
    end
  endtask

  // One clock: decide transfers from the pre-edge inputs, step the model, settle.
  task automatic cycle();
    int  c [2];
    bit  take [2];
    for (int d = 0; d < 2; d++) begin
      c[d]    = pick(d, valid_in);
      take[d] = (exp_ready(d) != 4'b0000);
    end
    @(posedge clk);
    if (!reset_n) begin
      model_reset();
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (take[d]) begin
          m_valid[d] = 1'b1;
          m_data[d]  = a_in[c[d]*8 +: 8];
          m_sel[d]   = c[d];
          if (d == 0) m_ptr[d] = (c[d] + 1) % N;
        end else if (ready_in) begin
          m_valid[d] = 1'b0;
        end
      end
    end
    #1;
  endtask

  task automatic apply_reset();
    reset_n  = 1'b0;
    valid_in = 4'b0000;
    ready_in = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    valid_in = 4'b1111;
    ready_in = 1'b1;
    a_in     = $urandom;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (rr_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", rr_valid); else passes++;
    checks++; if (rr_out !== 8'h00) $display("FAIL reset_out: got %h want 00", rr_out); else passes++;
    checks++; if (rr_sel !== 2'd0) $display("FAIL reset_sel: got %0d want 0", rr_sel); else passes++;
    checks++; if (rr_ready !== 4'b0000) $display("FAIL reset_ready_rr: got %b want 0000", rr_ready); else passes++;
    checks++; if (fp_ready !== 4'b0000) $display("FAIL reset_ready_fp: got %b want 0000", fp_ready); else passes++;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_single();
    apply_reset();
    a_in     = 32'h00A5_0000;
    valid_in = 4'b0100;
    ready_in = 1'b1;
    #1;
    checks++; if (rr_ready !== 4'b0100) $display("FAIL single_ready: got %b want 0100", rr_ready); else passes++;
    cycle();
    checks++; if (rr_out !== 8'hA5) $display("FAIL single_out: got %h want a5", rr_out); else passes++;
    checks++; if (rr_sel !== 2'd2) $display("FAIL single_sel: got %0d want 2", rr_sel); else passes++;
    checks++; if (rr_valid !== 1'b1) $display("FAIL single_valid: got %b want 1", rr_valid); else passes++;
    valid_in = 4'b0000;
    cycle();
    checks++; if (rr_valid !== 1'b0) $display("FAIL single_drain: got %b want 0", rr_valid); else passes++;
    checks++; if (rr_out !== 8'hA5) $display("FAIL single_hold: got %h want a5", rr_out); else passes++;
  endtask

  task automatic test_rr_fairness();
    apply_reset();
    a_in     = 32'h0403_0201;
    valid_in = 4'b1111;
    ready_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      checks++; if (rr_sel !== 2'(i % N)) $display("FAIL rr_sel[%0d]: got %0d want %0d", i, rr_sel, i % N); else passes++;
      checks++; if (rr_out !== 8'(i % N + 1)) $display("FAIL rr_out[%0d]: got %h want %h", i, rr_out, i % N + 1); else passes++;
      checks++; if (rr_valid !== 1'b1) $display("FAIL rr_valid[%0d]: got %b want 1", i, rr_valid); else passes++;
    end
  endtask

  task automatic test_fixed();
    apply_reset();
    a_in     = 32'hDD_CC_BB_AA;
    valid_in = 4'b1010;
    ready_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (fp_ready !== 4'b0010) $display("FAIL fixed_ready[%0d]: got %b want 0010", i, fp_ready); else passes++;
      cycle();
      checks++; if (fp_sel !== 2'd1) $display("FAIL fixed_sel[%0d]: got %0d want 1", i, fp_sel); else passes++;
      checks++; if (fp_out !== 8'hBB) $display("FAIL fixed_out[%0d]: got %h want bb", i, fp_out); else passes++;
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    a_in     = 32'h0000_003C;
    valid_in = 4'b0001;
    ready_in = 1'b1;
    cycle();
    ready_in = 1'b0;
    valid_in = 4'b1111;
    a_in     = 32'h1122_3344;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (rr_ready !== 4'b0000) $display("FAIL bp_ready[%0d]: got %b want 0000", i, rr_ready); else passes++;
      cycle();
      checks++; if (rr_out !== 8'h3C) $display("FAIL bp_out[%0d]: got %h want 3c", i, rr_out); else passes++;
      checks++; if (rr_valid !== 1'b1) $display("FAIL bp_valid[%0d]: got %b want 1", i, rr_valid); else passes++;
    end
    ready_in = 1'b1;
    #1;
    checks++; if (rr_ready !== 4'b0010) $display("FAIL bp_next_grant: got %b want 0010", rr_ready); else passes++;
    cycle();
    checks++; if (rr_sel !== 2'd1) $display("FAIL bp_next_sel: got %0d want 1", rr_sel); else passes++;
    checks++; if (rr_out !== 8'h33) $display("FAIL bp_next_out: got %h want 33", rr_out); else passes++;
  endtask

  task automatic test_async_reset();
    apply_reset();
    a_in     = $urandom;
    valid_in = 4'b1111;
    ready_in = 1'b1;
    cycle();
    cycle();
    checks++; if (rr_valid !== 1'b1) $display("FAIL ar_full: got %b want 1", rr_valid); else passes++;
    #3;
    reset_n = 1'b0;
    #1;
    checks++; if (rr_valid !== 1'b0) $display("FAIL ar_valid: got %b want 0", rr_valid); else passes++;
    checks++; if (rr_out !== 8'h00) $display("FAIL ar_out: got %h want 00", rr_out); else passes++;
    checks++; if (rr_sel !== 2'd0) $display("FAIL ar_sel: got %0d want 0", rr_sel); else passes++;
    model_reset();
    #2;
    reset_n = 1'b1;
    #1;
    checks++; if (rr_ready !== 4'b0001) $display("FAIL ar_first_grant: got %b want 0001", rr_ready); else passes++;
    cycle();
    checks++; if (rr_sel !== 2'd0) $display("FAIL ar_first_sel: got %0d want 0", rr_sel); else passes++;
    checks++; if (rr_out !== a_in[7:0]) $display("FAIL ar_first_out: got %h want %h", rr_out, a_in[7:0]); else passes++;
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 300; i++) begin
      valid_in = 4'($urandom_range(0, 15));
      ready_in = ($urandom_range(0, 3) != 0);
      a_in     = $urandom;
      #1;
      checks++; if (rr_ready !== exp_ready(0)) $display("FAIL rnd_rr_ready[%0d]: got %b want %b", i, rr_ready, exp_ready(0)); else passes++;
      checks++; if (fp_ready !== exp_ready(1)) $display("FAIL rnd_fp_ready[%0d]: got %b want %b", i, fp_ready, exp_ready(1)); else passes++;
      cycle();
      checks++; if (rr_valid !== m_valid[0]) $display("FAIL rnd_rr_valid[%0d]: got %b want %b", i, rr_valid, m_valid[0]); else passes++;
      checks++; if (rr_out !== m_data[0]) $display("FAIL rnd_rr_out[%0d]: got %h want %h", i, rr_out, m_data[0]); else passes++;
      checks++; if (rr_sel !== 2'(m_sel[0])) $display("FAIL rnd_rr_sel[%0d]: got %0d want %0d", i, rr_sel, m_sel[0]); else passes++;
      checks++; if (fp_valid !== m_valid[1]) $display("FAIL rnd_fp_valid[%0d]: got %b want %b", i, fp_valid, m_valid[1]); else passes++;
      checks++; if (fp_out !== m_data[1]) $display("FAIL rnd_fp_out[%0d]: got %h want %h", i, fp_out, m_data[1]); else passes++;
      checks++; if (fp_sel !== 2'(m_sel[1])) $display("FAIL rnd_fp_sel[%0d]: got %0d want %0d", i, fp_sel, m_sel[1]); else passes++;
    end
  endtask

  initial begin
    reset_n  = 1'b0;
    a_in     = 32'h0;
    valid_in = 4'b0000;
    ready_in = 1'b0;
    model_reset();
    test_reset();
    test_single();
    test_rr_fairness();
    test_fixed();
    test_backpressure();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
